// File: rtl/apb_i2c_pkg.sv
// Shared constants for the APB I2C controller: register map and FIFO sizing.
package apb_i2c_pkg;

    localparam logic [31:0] ADDR_TX      = 32'd0;
    localparam logic [31:0] ADDR_RX      = 32'd4;
    localparam logic [31:0] ADDR_CONFIG  = 32'd8;
    localparam logic [31:0] ADDR_TIMEOUT = 32'd12;

    localparam int I2C_DWIDTH     = 32;
    localparam int I2C_FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DWIDTH register array, one write port and one registered read port.
module fifo_mem_2p #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_d, rdata_q;

    // Storage is deliberately left unreset; only the output register is cleared.
    always_ff @(posedge PCLK) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) rdata_q <= '0;
        else          rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_i2c_fifo.sv
// Synchronous data FIFO between the APB front-end and the I2C core, with
// occupancy, full/empty/almost-full and sticky overflow/underflow flags.
module apb_i2c_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DWIDTH    = I2C_DWIDTH,
    parameter int DEPTH     = I2C_FIFO_DEPTH,
    parameter int AFULL_LVL = DEPTH - 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);

    logic [AW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [AW:0]   count_d, count_q;
    logic          rd_valid_d, rd_valid_q;
    logic          overflow_d, overflow_q, underflow_d, underflow_q;
    logic          wr_ok, rd_ok;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AFULL_C);

    // clr masks both ports so a flush never moves data in the same cycle.
    assign wr_ok = wr_en & ~full  & ~clr;
    assign rd_ok = rd_en & ~empty & ~clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_ok;
        overflow_d  = overflow_q  | (wr_en & full);
        underflow_d = underflow_q | (rd_en & empty);
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_ok && !rd_ok) count_d = count_q + (AW+1)'(1);
        if (rd_ok && !wr_ok) count_d = count_q - (AW+1)'(1);
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (wr_ok),
        .waddr   (wr_ptr_q),
        .wdata   (wr_data),
        .re      (rd_ok),
        .raddr   (rd_ptr_q),
        .rdata   (rd_data)
    );

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Directed bench for apb_i2c_fifo with hand-computed expectations.
module tb_apb_i2c_fifo;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        clr, wr_en, rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid, empty, full, almost_full, overflow, underflow;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    apb_i2c_fifo dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        PRESETn = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

        // 1. reset
        repeat (3) step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
        PRESETn = 1'b1;
        step();

        // 2. fill with A0..AF, then drain in order
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 32'hA0 + 32'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", 32'(full), (i == 15) ? 1 : 0);
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_valid", 32'(rd_valid), 1);
            chk("drain_data", rd_data, 32'hA0 + 32'(i));
        end
        rd_en = 1'b0;
        step();
        chk("drain_valid_end", 32'(rd_valid), 0);
        chk("drain_hold", rd_data, 32'hAF);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_underflow", 32'(underflow), 0);

        // 3. overflow on full FIFO
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 32'hB0 + 32'(i);
            step();
        end
        wr_data = 32'hDEAD;
        step();
        wr_en = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("ovf_read", rd_data, 32'hB0 + 32'(i));
        end
        rd_en = 1'b0;
        step();
        chk("ovf_empty", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_overflow", 32'(overflow), 0);

        // 4. empty with simultaneous write and read
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h55;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("emp_both_count", 32'(count), 1);
        chk("emp_both_underflow", 32'(underflow), 1);
        chk("emp_both_valid", 32'(rd_valid), 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("emp_read_data", rd_data, 32'h55);
        chk("emp_read_valid", 32'(rd_valid), 1);

        // 5. count=5, concurrent traffic wraps pointers
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 32'hC0 + 32'(i);
            step();
        end
        chk("mid_count", 32'(count), 5);
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 32'hC5 + 32'(i);
            step();
            chk("both_count", 32'(count), 5);
            chk("both_data", rd_data, 32'hC0 + 32'(i));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tail_data", rd_data, 32'hD4 + 32'(i));
        end
        rd_en = 1'b0;
        step();
        chk("tail_empty", 32'(empty), 1);

        // 6. clr overrides write; async reset mid-stream
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("uf_again", 32'(underflow), 1);
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 32'hE0 + 32'(i);
            step();
        end
        chk("clr_pre_count", 32'(count), 8);
        clr = 1'b1; wr_data = 32'hEE;
        step();
        clr = 1'b0; wr_en = 1'b0;
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_underflow", 32'(underflow), 0);
        chk("clr_valid", 32'(rd_valid), 0);
        chk("clr_hold", rd_data, 32'hD8);
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'hF0 + 32'(i);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        chk("pre_rst_data", rd_data, 32'hF0);
        wr_en = 1'b1; wr_data = 32'hF9;
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_data", rd_data, 0);
        chk("arst_valid", 32'(rd_valid), 0);
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        PRESETn = 1'b1;
        step();
        chk("post_rst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
